// File: rtl/spiker_frame_streamer_if.sv
// rtl/spiker_frame_streamer_if.sv - beat stream carrying one frame word with its index and last flag
interface spiker_frame_streamer_if #(
    parameter int WIDTH = 32,
    parameter int IDX_W = 5
);
    logic [WIDTH-1:0] data;
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             last;
    logic             ready;

    modport master (output data, output idx, output valid, output last, input ready);
    modport slave  (input data, input idx, input valid, input last, output ready);
endinterface

// File: rtl/spiker_frame_streamer.sv
// rtl/spiker_frame_streamer.sv - snapshots a spike frame and streams it out dense or sparse
module spiker_frame_streamer #(
    parameter int WIDTH    = 32,
    parameter int N_SPIKES = 784,
    parameter int N_REG    = 25
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [N_REG*WIDTH-1:0]   regs_i,
    input  logic                     sample_i,
    input  logic                     sparse_i,
    spiker_frame_streamer_if.master  strm,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     overrun_o
);

    localparam int N_BEATS = (N_SPIKES + WIDTH - 1) / WIDTH;
    localparam int IDX_W   = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;

    if (N_REG < N_BEATS) begin : g_check_nreg
        $fatal(1, "N_REG must cover every beat of the frame");
    end

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shadow_q [N_BEATS];
    logic [N_BEATS-1:0] nz_mask_q;
    logic               sparse_q;
    logic [WIDTH-1:0]   data_q;
    logic [IDX_W-1:0]   ptr_q;
    logic               valid_q;
    logic               last_q;
    logic               busy_q;
    logic               done_q;
    logic               overrun_q;

    logic [N_BEATS*WIDTH-1:0] cap_flat;
    logic [WIDTH-1:0]         cap_word [N_BEATS];
    logic [N_BEATS-1:0]       nz_cap;
    logic [IDX_W:0]           f_cap, f_cap2, f_nxt, f_nxt2;
    logic [IDX_W-1:0]         cap_first, nxt_ptr;
    logic                     cap_last, nxt_last;

    // Lowest set mask bit at or above start; MSB of the result flags a hit.
    function automatic logic [IDX_W:0] find_from(input logic [N_BEATS-1:0] mask, input int start);
        logic [IDX_W:0] r;
        r = '0;
        for (int i = N_BEATS - 1; i >= 0; i--) begin
            if (mask[i] && i >= start) r = {1'b1, IDX_W'(i)};
        end
        return r;
    endfunction

    always_comb begin
        cap_flat = '0;
        for (int i = 0; i < N_BEATS * WIDTH; i++) begin
            cap_flat[i] = (i < N_SPIKES) ? regs_i[i] : 1'b0;
        end
        nz_cap = '0;
        for (int i = 0; i < N_BEATS; i++) begin
            cap_word[i] = cap_flat[i*WIDTH +: WIDTH];
            nz_cap[i]   = |cap_flat[i*WIDTH +: WIDTH];
        end

        f_cap     = find_from(nz_cap, 0);
        cap_first = sparse_i ? f_cap[IDX_W-1:0] : '0;
        f_cap2    = find_from(nz_cap, int'(cap_first) + 1);
        cap_last  = sparse_i ? !f_cap2[IDX_W] : (N_BEATS == 1);

        f_nxt     = find_from(nz_mask_q, int'(ptr_q) + 1);
        nxt_ptr   = sparse_q ? f_nxt[IDX_W-1:0] : ptr_q + 1'b1;
        f_nxt2    = find_from(nz_mask_q, int'(nxt_ptr) + 1);
        nxt_last  = sparse_q ? !f_nxt2[IDX_W] : (nxt_ptr == IDX_W'(N_BEATS - 1));
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= S_IDLE;
            for (int i = 0; i < N_BEATS; i++) shadow_q[i] <= '0;
            nz_mask_q <= '0;
            sparse_q  <= 1'b0;
            data_q    <= '0;
            ptr_q     <= '0;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= sample_i && busy_q;
            case (state_q)
                S_IDLE: begin
                    if (sample_i) begin
                        for (int i = 0; i < N_BEATS; i++) shadow_q[i] <= cap_word[i];
                        nz_mask_q <= nz_cap;
                        sparse_q  <= sparse_i;
                        busy_q    <= 1'b1;
                        if (!sparse_i || (nz_cap != '0)) begin
                            state_q <= S_STREAM;
                            valid_q <= 1'b1;
                            ptr_q   <= cap_first;
                            data_q  <= cap_word[cap_first];
                            last_q  <= cap_last;
                        end else begin
                            state_q <= S_DONE;
                        end
                    end
                end
                S_STREAM: begin
                    if (valid_q && strm.ready) begin
                        if (last_q) begin
                            state_q <= S_DONE;
                            valid_q <= 1'b0;
                            last_q  <= 1'b0;
                            ptr_q   <= '0;
                            data_q  <= '0;
                            done_q  <= 1'b1;
                        end else begin
                            ptr_q  <= nxt_ptr;
                            data_q <= shadow_q[nxt_ptr];
                            last_q <= nxt_last;
                        end
                    end
                end
                S_DONE: begin
                    // An empty sparse frame arrives here with done_q low and spends one extra cycle.
                    if (done_q) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end else begin
                        done_q <= 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign strm.data  = data_q;
    assign strm.idx   = ptr_q;
    assign strm.valid = valid_q;
    assign strm.last  = last_q;
    assign busy_o     = busy_q;
    assign done_o     = done_q;
    assign overrun_o  = overrun_q;

endmodule

// File: tb/tb_spiker_frame_streamer.sv
// tb/tb_spiker_frame_streamer.sv - directed self-checking bench for spiker_frame_streamer
module tb_spiker_frame_streamer;

    logic          clk = 1'b0;
    logic          rst;
    logic [799:0]  regs;
    logic          sample;
    logic          sparse;
    logic          busy, done, overrun;
    int            n_cmp = 0;
    int            n_err = 0;

    spiker_frame_streamer_if #(.WIDTH(32), .IDX_W(5)) strm ();

    spiker_frame_streamer #(.WIDTH(32), .N_SPIKES(784), .N_REG(25)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .regs_i    (regs),
        .sample_i  (sample),
        .sparse_i  (sparse),
        .strm      (strm),
        .busy_o    (busy),
        .done_o    (done),
        .overrun_o (overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] dense_word(input int b);
        return (b == 24) ? 32'h0000_FFFF : 32'(b + 1);
    endfunction

    task automatic load_dense();
        regs = '0;
        for (int i = 0; i < 24; i++) regs[i*32 +: 32] = 32'(i + 1);
        regs[24*32 +: 32] = 32'hFFFF_FFFF;
    endtask

    task automatic pulse_sample();
        @(negedge clk);
        sample = 1'b1;
        @(negedge clk);
        sample = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sample = 1'b0; sparse = 1'b0; strm.ready = 1'b1; regs = '0;
        @(negedge clk);
        n_cmp++;
        if ({strm.valid, strm.last, strm.idx, strm.data, busy, done, overrun} !== 42'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b l=%b i=%0d d=%h b=%b dn=%b o=%b, want all 0",
                     strm.valid, strm.last, strm.idx, strm.data, busy, done, overrun);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_dense();
        load_dense(); sparse = 1'b0; strm.ready = 1'b1;
        pulse_sample();
        for (int b = 0; b < 25; b++) begin
            n_cmp++;
            if ({strm.valid, strm.idx, strm.data, strm.last} !== {1'b1, 5'(b), dense_word(b), b == 24}) begin
                n_err++;
                $display("FAIL dense_beat%0d: got v=%b i=%0d d=%h l=%b, want v=1 i=%0d d=%h l=%b",
                         b, strm.valid, strm.idx, strm.data, strm.last, b, dense_word(b), b == 24);
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({done, busy, strm.valid} !== 3'b110) begin
            n_err++;
            $display("FAIL dense_done: got done=%b busy=%b valid=%b, want 1 1 0", done, busy, strm.valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, busy, strm.idx, strm.data} !== 39'b0) begin
            n_err++;
            $display("FAIL dense_idle: got done=%b busy=%b idx=%0d data=%h, want all 0", done, busy, strm.idx, strm.data);
        end
    endtask

    task automatic test_backpressure();
        logic pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        int   b = 0;
        int   cyc = 0;
        load_dense(); sparse = 1'b0;
        strm.ready = 1'b1;
        pulse_sample();
        while (b < 25 && cyc < 400) begin
            strm.ready = pat[cyc % 6];
            n_cmp++;
            if ({strm.valid, strm.idx, strm.data, strm.last} !== {1'b1, 5'(b), dense_word(b), b == 24}) begin
                n_err++;
                $display("FAIL bp_beat%0d_cyc%0d: got v=%b i=%0d d=%h l=%b, want v=1 i=%0d d=%h l=%b",
                         b, cyc, strm.valid, strm.idx, strm.data, strm.last, b, dense_word(b), b == 24);
            end
            if (strm.ready) b++;
            cyc++;
            @(negedge clk);
        end
        n_cmp++;
        if (b != 25 || done !== 1'b1) begin
            n_err++;
            $display("FAIL bp_complete: got beats=%0d done=%b, want beats=25 done=1", b, done);
        end
        strm.ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_sparse();
        regs = '0;
        regs[3*32 +: 32]  = 32'h1;
        regs[20*32 +: 32] = 32'h8000_0000;
        sparse = 1'b1; strm.ready = 1'b1;
        pulse_sample();
        n_cmp++;
        if ({strm.valid, strm.idx, strm.data, strm.last} !== {1'b1, 5'd3, 32'h1, 1'b0}) begin
            n_err++;
            $display("FAIL sparse_beat0: got v=%b i=%0d d=%h l=%b, want v=1 i=3 d=00000001 l=0",
                     strm.valid, strm.idx, strm.data, strm.last);
        end
        @(negedge clk);
        n_cmp++;
        if ({strm.valid, strm.idx, strm.data, strm.last} !== {1'b1, 5'd20, 32'h8000_0000, 1'b1}) begin
            n_err++;
            $display("FAIL sparse_beat1: got v=%b i=%0d d=%h l=%b, want v=1 i=20 d=80000000 l=1",
                     strm.valid, strm.idx, strm.data, strm.last);
        end
        @(negedge clk);
        n_cmp++;
        if ({done, strm.valid} !== 2'b10) begin
            n_err++;
            $display("FAIL sparse_done: got done=%b valid=%b, want 1 0", done, strm.valid);
        end
        @(negedge clk);
    endtask

    task automatic test_sparse_empty();
        regs = '0;
        regs[24*32 +: 32] = 32'hFFFF_0000;
        sparse = 1'b1; strm.ready = 1'b1;
        pulse_sample();
        n_cmp++;
        if ({strm.valid, done, busy} !== 3'b001) begin
            n_err++;
            $display("FAIL empty_t1: got valid=%b done=%b busy=%b, want 0 0 1", strm.valid, done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({strm.valid, done, busy} !== 3'b011) begin
            n_err++;
            $display("FAIL empty_t2: got valid=%b done=%b busy=%b, want 0 1 1", strm.valid, done, busy);
        end
        @(negedge clk);
        n_cmp++;
        if ({strm.valid, done, busy} !== 3'b000) begin
            n_err++;
            $display("FAIL empty_t3: got valid=%b done=%b busy=%b, want 0 0 0", strm.valid, done, busy);
        end
        sparse = 1'b0;
    endtask

    task automatic test_overrun();
        load_dense(); sparse = 1'b0; strm.ready = 1'b1;
        pulse_sample();
        for (int b = 0; b < 25; b++) begin
            n_cmp++;
            if ({strm.valid, strm.idx, strm.data, overrun} !== {1'b1, 5'(b), dense_word(b), b == 6}) begin
                n_err++;
                $display("FAIL ovr_beat%0d: got v=%b i=%0d d=%h o=%b, want v=1 i=%0d d=%h o=%b",
                         b, strm.valid, strm.idx, strm.data, overrun, b, dense_word(b), b == 6);
            end
            if (b == 5) begin
                sample = 1'b1;
                regs = '0;
            end else begin
                sample = 1'b0;
            end
            @(negedge clk);
        end
        n_cmp++;
        if ({done, overrun} !== 2'b10) begin
            n_err++;
            $display("FAIL ovr_done: got done=%b overrun=%b, want 1 0", done, overrun);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midstream();
        load_dense(); sparse = 1'b0; strm.ready = 1'b1;
        pulse_sample();
        repeat (10) @(negedge clk);
        n_cmp++;
        if (strm.idx !== 5'd10) begin
            n_err++;
            $display("FAIL rst_pre_idx: got %0d, want 10", strm.idx);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if ({strm.valid, strm.last, strm.idx, strm.data, busy, done, overrun} !== 42'b0) begin
            n_err++;
            $display("FAIL rst_mid_outputs: got v=%b l=%b i=%0d d=%h b=%b dn=%b o=%b, want all 0",
                     strm.valid, strm.last, strm.idx, strm.data, busy, done, overrun);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++;
            if ({done, strm.valid, busy} !== 3'b000) begin
                n_err++;
                $display("FAIL rst_quiet%0d: got done=%b valid=%b busy=%b, want 0 0 0", c, done, strm.valid, busy);
            end
        end
        pulse_sample();
        n_cmp++;
        if ({strm.valid, strm.idx, strm.data} !== {1'b1, 5'd0, 32'h1}) begin
            n_err++;
            $display("FAIL rst_restart: got v=%b i=%0d d=%h, want v=1 i=0 d=00000001", strm.valid, strm.idx, strm.data);
        end
        repeat (30) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_dense();
        test_backpressure();
        test_sparse();
        test_sparse_empty();
        test_overrun();
        test_reset_midstream();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
